// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer.
// Each channel has its own two-flop synchroniser, a stability counter and a
// debounced level register. A new level is accepted only after the
// synchronised input has disagreed with the current level for
// DEBOUNCE_CYCLES consecutive clock edges. One-cycle pressed/released pulses
// are issued together with the level change.
module button_debouncer #(
  parameter int   N_BUTTONS       = 3,
  parameter int   DEBOUNCE_CYCLES = 400000,
  parameter logic INVERT          = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  output logic [N_BUTTONS-1:0] buttons,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] released
);

  // Wide enough to hold DEBOUNCE_CYCLES itself, so the counter can never wrap.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next differing edge accepts the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] sync_s1;
  logic [N_BUTTONS-1:0] sync_s2;

  logic [CNT_W-1:0]     count_q [N_BUTTONS];
  logic [CNT_W-1:0]     count_d [N_BUTTONS];

  logic [N_BUTTONS-1:0] buttons_d;
  logic [N_BUTTONS-1:0] pressed_d;
  logic [N_BUTTONS-1:0] released_d;

  // Two-flop synchroniser; polarity is normalised before the first flop so
  // everything downstream works in "1 = pressed".
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse s1/s2 into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= buttons_raw ^ {N_BUTTONS{INVERT}};
      sync_s2 <= sync_s1;
    end
  end

  // Per-channel next-state: clear on agreement, count on disagreement,
  // accept and pulse once the disagreement has lasted long enough.
  // NOTE: every output of this block gets a default before any branch; a
  // missing default would infer a latch.
  always_comb begin
    buttons_d  = buttons;
    pressed_d  = '0;
    released_d = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      count_d[i] = '0;
      if (sync_s2[i] != buttons[i]) begin
        if (count_q[i] == CNT_LAST) begin
          buttons_d[i]  = sync_s2[i];
          pressed_d[i]  = sync_s2[i];
          released_d[i] = ~sync_s2[i];
        end else begin
          count_d[i] = count_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Counter, level and pulse registers; reset aborts any count in progress.
  // NOTE: the counter array is a bank of individual flops, not a RAM, so it is
  // safe (and required) to clear it in the asynchronous reset branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        count_q[i] <= '0;
      end
      buttons  <= '0;
      pressed  <= '0;
      released <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        count_q[i] <= count_d[i];
      end
      buttons  <= buttons_d;
      pressed  <= pressed_d;
      released <= released_d;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with DEBOUNCE_CYCLES=4.
// A second instance with INVERT=1 and a third with DEBOUNCE_CYCLES=1 share
// the clock and reset.
module tb_button_debouncer;

  localparam int N = 3;

  logic         clk;
  logic         reset;
  logic [N-1:0] raw;
  logic [N-1:0] raw_inv;
  logic [N-1:0] buttons,      pressed,      released;
  logic [N-1:0] buttons_inv,  pressed_inv,  released_inv;
  logic [N-1:0] buttons_fast, pressed_fast, released_fast;

  int tests;
  int fails;

  button_debouncer #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(4), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .buttons_raw(raw),
    .buttons(buttons), .pressed(pressed), .released(released)
  );

  button_debouncer #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(4), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .buttons_raw(raw_inv),
    .buttons(buttons_inv), .pressed(pressed_inv), .released(released_inv)
  );

  button_debouncer #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(1), .INVERT(1'b0)) dut_fast (
    .clk(clk), .reset(reset), .buttons_raw(raw),
    .buttons(buttons_fast), .pressed(pressed_fast), .released(released_fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // {buttons, pressed, released} of the main instance.
  function automatic logic [31:0] outs();
    return {23'd0, buttons, pressed, released};
  endfunction

  initial begin
    tests   = 0;
    fails   = 0;
    raw     = '0;
    raw_inv = 3'b111;
    reset   = 1'b1;
    tick(2);
    check("reset_outs", outs(), 32'h0);
    check("reset_inv_outs", {23'd0, buttons_inv, pressed_inv, released_inv}, 32'h0);
    reset = 1'b0;
    tick(3);

    // Bounce: bit 0 high for 3 cycles then low; no output activity.
    raw = 3'b001;
    for (int t = 1; t <= 12; t++) begin
      if (t == 4) raw = 3'b000;
      check($sformatf("bounce_t%0d", t), outs(), 32'h0);
      tick();
    end
    check("bounce_end", outs(), 32'h0);

    // Clean press 000 -> 001: accepted on edge 6 (edge 3 for DEBOUNCE_CYCLES=1).
    raw = 3'b001;
    tick(2);
    check("fast_before", {29'd0, buttons_fast}, 32'h0);
    tick();
    check("fast_accept", {29'd0, buttons_fast, pressed_fast}, {26'd0, 3'b001, 3'b001});
    tick(2);
    check("press_edge5", outs(), 32'h0);
    tick();
    check("press_edge6", outs(), {23'd0, 3'b001, 3'b001, 3'b000});
    tick();
    check("press_edge7", outs(), {23'd0, 3'b001, 3'b000, 3'b000});

    // Reach buttons=011.
    raw = 3'b011;
    tick(6);
    check("press_b1", outs(), {23'd0, 3'b011, 3'b010, 3'b000});
    tick();
    check("press_b1_after", outs(), {23'd0, 3'b011, 3'b000, 3'b000});
    check("inv_held_low", {29'd0, buttons_inv}, 32'h0);

    // Simultaneous release of bit 0 and press of bit 2.
    raw = 3'b110;
    tick(5);
    check("simul_edge5", outs(), {23'd0, 3'b011, 3'b000, 3'b000});
    tick();
    check("simul_edge6", outs(), {23'd0, 3'b110, 3'b100, 3'b001});
    tick();
    check("simul_edge7", outs(), {23'd0, 3'b110, 3'b000, 3'b000});

    // Reset mid-count: bit 0 counting, async reset between edges.
    raw = 3'b111;
    tick(4);
    check("pre_reset", {29'd0, buttons}, {29'd0, 3'b110});
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", outs(), 32'h0);
    tick(2);
    check("reset_held", outs(), 32'h0);
    reset = 1'b0;
    tick(5);
    check("after_rst_edge5", outs(), 32'h0);
    tick();
    check("after_rst_edge6", outs(), {23'd0, 3'b111, 3'b111, 3'b000});
    tick();
    check("after_rst_edge7", outs(), {23'd0, 3'b111, 3'b000, 3'b000});

    // Inverted inputs: 111 is idle; 101 presses bit 1.
    check("inv_idle", {23'd0, buttons_inv, pressed_inv, released_inv}, 32'h0);
    raw_inv = 3'b101;
    tick(5);
    check("inv_edge5", {23'd0, buttons_inv, pressed_inv, released_inv}, 32'h0);
    tick();
    check("inv_edge6", {23'd0, buttons_inv, pressed_inv, released_inv},
          {23'd0, 3'b010, 3'b010, 3'b000});
    tick();
    check("inv_edge7", {23'd0, buttons_inv, pressed_inv, released_inv},
          {23'd0, 3'b010, 3'b000, 3'b000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
